// File: rtl/mac_filter_arbiter.sv
// Packet-granular round-robin arbiter feeding one mac_filter from NUM_PORTS
// AXI-Stream ingress ports; tags beats with source port, counts packets per port.
module mac_filter_arbiter #(
   parameter int DATA_W    = 32,
   parameter int NUM_PORTS = 2,
   parameter int SRC_W     = $clog2(NUM_PORTS),
   parameter int CNT_W     = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_PORTS-1:0]          s_tvalid,
   output logic [NUM_PORTS-1:0]          s_tready,
   input  logic [NUM_PORTS*DATA_W-1:0]   s_tdata,
   input  logic [NUM_PORTS-1:0]          s_tlast,
   output logic                          m_tvalid,
   input  logic                          m_tready,
   output logic [DATA_W-1:0]             m_tdata,
   output logic                          m_tlast,
   output logic [SRC_W-1:0]              m_tsrc,
   output logic                          busy,
   output logic [NUM_PORTS*CNT_W-1:0]    pkt_cnt
);

   localparam int              IW        = SRC_W + 1;
   localparam logic [IW-1:0]   NP        = IW'(NUM_PORTS);
   localparam logic [IW-1:0]   IDX_ONE   = IW'(1);
   localparam logic [SRC_W-1:0] LAST_PORT = SRC_W'(NUM_PORTS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic {IDLE, PASS} state_e;

   state_e                           state_q, state_d;
   logic [SRC_W-1:0]                 grant_q, grant_d;
   logic [SRC_W-1:0]                 last_grant_q, last_grant_d;
   logic [NUM_PORTS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
   logic [NUM_PORTS-1:0][DATA_W-1:0] data_a;

   logic [2*NUM_PORTS-1:0]           req_dbl;
   logic [NUM_PORTS-1:0]             req_rot;
   logic [IW-1:0]                    start, off, sum;
   logic [SRC_W-1:0]                 pick;
   logic                             pick_vld;

   assign data_a  = s_tdata;
   assign pkt_cnt = cnt_q;

   // Rotate requests so bit 0 is the port just after last_grant; the lowest
   // set bit of the rotated vector is then the round-robin winner.
   always_comb begin
      start    = (last_grant_q == LAST_PORT) ? '0 : ({1'b0, last_grant_q} + IDX_ONE);
      req_dbl  = {s_tvalid, s_tvalid};
      req_rot  = req_dbl[start +: NUM_PORTS];
      pick_vld = |s_tvalid;
      off      = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (req_rot[k]) off = IW'(k);
      end
      sum  = start + off;
      pick = (sum >= NP) ? SRC_W'(sum - NP) : SRC_W'(sum);
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      s_tready     = '0;
      m_tvalid     = 1'b0;
      m_tdata      = '0;
      m_tlast      = 1'b0;
      m_tsrc       = '0;
      busy         = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               grant_d = pick;
               state_d = PASS;
            end
         end
         PASS: begin
            busy              = 1'b1;
            m_tvalid          = s_tvalid[grant_q];
            m_tdata           = data_a[grant_q];
            m_tlast           = s_tlast[grant_q];
            m_tsrc            = grant_q;
            s_tready[grant_q] = m_tready;
            if (s_tvalid[grant_q] && m_tready && s_tlast[grant_q]) begin
               last_grant_d   = grant_q;
               cnt_d[grant_q] = cnt_q[grant_q] + CNT_ONE;
               state_d        = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= LAST_PORT;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mac_filter_arbiter.sv
// Directed bench for mac_filter_arbiter: drivers per port, a beat scoreboard
// of expected {last, src, data}, and directed checks around each scenario.
module tb_mac_filter_arbiter;

   localparam int DW = 32;
   localparam int NP = 2;
   localparam int SW = 1;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [NP-1:0] s_tvalid, s_tready, s_tlast;
   logic [NP*DW-1:0] s_tdata;
   logic          m_tvalid, m_tready, m_tlast, busy;
   logic [DW-1:0] m_tdata;
   logic [SW-1:0] m_tsrc;
   logic [NP*CW-1:0] pkt_cnt;

   logic          vld0, vld1, lst0, lst1;
   logic [DW-1:0] dat0, dat1;
   logic          mrdy_fix, tgl, tgl_q = 1'b0;
   logic          gap_chk, prev_last = 1'b0;
   int            cyc = 0, last_cyc = 0;
   int            nchk = 0, nerr = 0;
   logic [DW+SW:0] eq[$];
   logic [7:0]    msg [20] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78,
                               8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h01, 8'h02, 8'h03,
                               8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

   assign s_tvalid = {vld1, vld0};
   assign s_tlast  = {lst1, lst0};
   assign s_tdata  = {dat1, dat0};
   assign m_tready = tgl ? tgl_q : mrdy_fix;

   mac_filter_arbiter #(.DATA_W(DW), .NUM_PORTS(NP), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
      .m_tsrc(m_tsrc), .busy(busy), .pkt_cnt(pkt_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      #1 tgl_q = ~tgl_q;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] beat_data(input int base, input int i);
      if (base == 0) return {24'h0, msg[i]};
      return DW'(base + i);
   endfunction

   task automatic set_port(input int p, input logic v, input logic [DW-1:0] d, input logic l);
      if (p == 0) begin vld0 = v; dat0 = d; lst0 = l; end
      else        begin vld1 = v; dat1 = d; lst1 = l; end
   endtask

   task automatic exp_pkt(input int p, input int n, input int base);
      for (int i = 0; i < n; i++) eq.push_back({(i == n - 1), SW'(p), beat_data(base, i)});
   endtask

   // Returns at posedge+1 after the handshake of the currently presented beat.
   task automatic wait_hs(input int p);
      logic [NP-1:0] sr;
      logic hs = 1'b0;
      int t = 0;
      while (!hs && t < 200) begin
         @(negedge clk);
         sr = s_tready >> p;
         hs = sr[0];
         @(posedge clk); #1;
         t++;
      end
      if (!hs) chk("handshake_timeout", 64'd0, 64'd1);
   endtask

   task automatic drv(input int p, input int n, input int base, input int gap_at, input int gap_len);
      for (int i = 0; i < n; i++) begin
         if (i == gap_at) begin
            set_port(p, 1'b0, '0, 1'b0);
            repeat (gap_len) @(posedge clk);
            #1;
         end
         set_port(p, 1'b1, beat_data(base, i), (i == n - 1));
         wait_hs(p);
      end
      set_port(p, 1'b0, '0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk); #1;
   endtask

   // Scoreboard: every accepted beat must be the next expected one.
   always @(negedge clk) begin
      logic [DW+SW:0] e;
      logic [NP-1:0]  one, exp_rdy;
      one = NP'(1);
      if (rst) prev_last = 1'b0;
      else begin
         if (busy && eq.size() > 0) begin
            exp_rdy = m_tready ? (one << eq[0][DW +: SW]) : '0;
            chk("s_tready", s_tready, exp_rdy);
         end
         if (!busy) chk("idle_outputs", {m_tvalid, m_tlast, m_tsrc, m_tdata, s_tready}, 64'd0);
         if (m_tvalid && m_tready) begin
            if (eq.size() == 0) chk("extra_beat", 64'd1, 64'd0);
            else begin
               e = eq.pop_front();
               chk("m_tdata", m_tdata, e[DW-1:0]);
               chk("m_tsrc", m_tsrc, e[DW +: SW]);
               chk("m_tlast", m_tlast, e[DW+SW]);
               if (gap_chk && prev_last) chk("packet_gap", cyc - last_cyc, 64'd2);
               prev_last = m_tlast;
               if (m_tlast) last_cyc = cyc;
            end
         end
      end
   end

   initial begin
      rst = 1'b1; mrdy_fix = 1'b1; tgl = 1'b0; gap_chk = 1'b0;
      set_port(0, 1'b0, '0, 1'b0);
      set_port(1, 1'b0, '0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_tvalid", m_tvalid, 64'd0);
      chk("rst_s_tready", s_tready, 64'd0);
      chk("rst_busy", busy, 64'd0);
      chk("rst_m_tdata", m_tdata, 64'd0);
      chk("rst_m_tsrc_tlast", {m_tsrc, m_tlast}, 64'd0);
      chk("rst_pkt_cnt", pkt_cnt, 64'd0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      // 20-beat packet on port 0
      exp_pkt(0, 20, 0);
      drv(0, 20, 0, -1, 0);
      chk("t1_busy_after_last", busy, 64'd0);
      chk("t1_cnt0", pkt_cnt[CW-1:0], 64'd1);

      // Both ports from reset, twice: order 0,1,0,1
      do_reset();
      gap_chk = 1'b1;
      repeat (2) begin
         exp_pkt(0, 5, 'h100);
         exp_pkt(1, 5, 'h200);
         fork
            drv(0, 5, 'h100, -1, 0);
            drv(1, 5, 'h200, -1, 0);
         join
      end
      chk("t2_cnt0", pkt_cnt[CW-1:0], 64'd2);
      chk("t2_cnt1", pkt_cnt[2*CW-1:CW], 64'd2);

      // Port 0 requests while port 1 holds the grant
      exp_pkt(1, 8, 'h300);
      exp_pkt(0, 3, 'h400);
      fork
         drv(1, 8, 'h300, -1, 0);
         begin
            repeat (3) @(posedge clk);
            #1 drv(0, 3, 'h400, -1, 0);
         end
      join
      chk("t3_cnt0", pkt_cnt[CW-1:0], 64'd3);
      chk("t3_cnt1", pkt_cnt[2*CW-1:CW], 64'd3);

      // m_tready toggling plus a 3-cycle valid drop mid-packet
      gap_chk = 1'b0;
      tgl = 1'b1;
      exp_pkt(0, 8, 'h500);
      drv(0, 8, 'h500, 4, 3);
      tgl = 1'b0;
      chk("t4_cnt0", pkt_cnt[CW-1:0], 64'd4);

      // Counter wrap on port 0
      gap_chk = 1'b1;
      for (int k = 0; k < 251; k++) begin
         exp_pkt(0, 1, 'h600 + k);
         drv(0, 1, 'h600 + k, -1, 0);
      end
      chk("t5_cnt0_max", pkt_cnt[CW-1:0], 64'hFF);
      exp_pkt(0, 1, 'h6FF);
      drv(0, 1, 'h6FF, -1, 0);
      chk("t5_cnt0_wrap", pkt_cnt[CW-1:0], 64'h00);
      chk("t5_cnt1_kept", pkt_cnt[2*CW-1:CW], 64'd3);

      // Reset while beat 3 of a 10-beat packet is presented
      gap_chk = 1'b0;
      eq.push_back({1'b0, 1'b0, 32'h700});
      eq.push_back({1'b0, 1'b0, 32'h701});
      set_port(0, 1'b1, 32'h700, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1 dat0 = 32'h701;
      @(posedge clk); #1 dat0 = 32'h702;
      #2 rst = 1'b1;
      #1;
      chk("t6_m_tvalid", m_tvalid, 64'd0);
      chk("t6_s_tready", s_tready, 64'd0);
      chk("t6_busy", busy, 64'd0);
      chk("t6_m_data_last_src", {m_tdata, m_tlast, m_tsrc}, 64'd0);
      chk("t6_pkt_cnt", pkt_cnt, 64'd0);
      set_port(0, 1'b0, '0, 1'b0);
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      chk("t6_idle_after_release", {busy, m_tvalid}, 64'd0);
      exp_pkt(0, 2, 'h800);
      exp_pkt(1, 2, 'h900);
      fork
         drv(0, 2, 'h800, -1, 0);
         drv(1, 2, 'h900, -1, 0);
      join
      chk("t6_cnt0", pkt_cnt[CW-1:0], 64'd1);
      chk("t6_cnt1", pkt_cnt[2*CW-1:CW], 64'd1);

      repeat (2) @(posedge clk);
      chk("queue_drained", eq.size(), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
